// File: rtl/serial_adder.sv
// Bit-serial adder: one operand bit per clock, LSB first, result built in a shift register.
// Define SERIAL_ADDER_SUB_EN to add the sub port and two's-complement subtraction.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic             done
);
    // state | meaning
    // IDLE  | waiting for start
    // ADD   | one bit per cycle, LSB first, WIDTH cycles
    // DONE  | sum/carry valid, done pulse; a new start is accepted here too
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt;
    logic             sub_q;
    logic             sub_in;
    logic             accept;
    logic             last_bit;
    logic             b_bit;
    logic             p;
    logic             g1;
    logic             g2;
    logic             s_bit;
    logic             c_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sub_q <= 1'b0;
        end else if (accept) begin
            sub_q <= sub;
        end
    end
`else
    assign sub_in = 1'b0;
    assign sub_q  = 1'b0;
`endif

    assign busy     = (state == ADD);
    assign done     = (state == DONE);
    assign accept   = start && !busy;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Full adder from two half adders; subtraction inverts B and seeds carry with 1.
    assign b_bit = b_q[0] ^ sub_q;
    assign p     = a_q[0] ^ b_bit;
    assign g1    = a_q[0] & b_bit;
    assign s_bit = p ^ carry;
    assign g2    = p & carry;
    assign c_nxt = g1 | g2;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? ADD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            cnt   <= '0;
            sum   <= '0;
            carry <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                cnt   <= '0;
                carry <= sub_in;
            end else if (busy) begin
                a_q   <= a_q >> 1;
                b_q   <= b_q >> 1;
                sum   <= {s_bit, sum[WIDTH-1:1]};
                carry <= c_nxt;
                cnt   <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: WIDTH=8 directed vectors plus WIDTH=2 exhaustive sweep.
// Subtraction vectors run only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;
`ifdef SERIAL_ADDER_SUB_EN
    localparam int NMODE = 2;
`else
    localparam int NMODE = 1;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start8;
    logic       start2;
    logic [7:0] a8;
    logic [7:0] b8;
    logic [7:0] sum8;
    logic [1:0] a2;
    logic [1:0] b2;
    logic [1:0] sum2;
    logic       sub8;
    logic       sub2;
    logic       carry8;
    logic       busy8;
    logic       done8;
    logic       carry2;
    logic       busy2;
    logic       done2;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start8),
        .a     (a8),
        .b     (b8),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub8),
`endif
        .sum   (sum8),
        .carry (carry8),
        .busy  (busy8),
        .done  (done8)
    );

    serial_adder #(.WIDTH(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start2),
        .a     (a2),
        .b     (b2),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub2),
`endif
        .sum   (sum2),
        .carry (carry2),
        .busy  (busy2),
        .done  (done2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called 1ns after an edge in IDLE or DONE; returns 1ns after the accepting edge.
    task automatic launch8(input logic [7:0] aa, input logic [7:0] bb, input logic s);
        a8     = aa;
        b8     = bb;
        sub8   = s;
        start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    // Walks the 8 ADD cycles, then checks the DONE cycle; optionally pokes start mid-operation.
    task automatic finish8(input string tag, input logic [7:0] es, input logic ec, input bit poke);
        for (int i = 0; i < 8; i++) begin
            check({tag, " busy/done in ADD"}, {busy8, done8}, 32'd2);
            if (poke && i == 2) begin
                start8 = 1'b1;
                a8     = 8'hFF;
                b8     = 8'hFF;
                sub8   = ~sub8;
            end
            if (poke && i == 3) start8 = 1'b0;
            @(posedge clk); #1;
        end
        check({tag, " busy/done in DONE"}, {busy8, done8}, 32'd1);
        check({tag, " sum"}, sum8, es);
        check({tag, " carry"}, carry8, ec);
    endtask

    task automatic idle8(input string tag, input logic [7:0] es, input logic ec);
        @(posedge clk); #1;
        check({tag, " busy/done idle"}, {busy8, done8}, 32'd0);
        check({tag, " sum held"}, sum8, es);
        check({tag, " carry held"}, carry8, ec);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_v;
        rst    = 1'b1;
        start8 = 1'b0;
        start2 = 1'b0;
        a8     = '0;
        b8     = '0;
        a2     = '0;
        b2     = '0;
        sub8   = 1'b0;
        sub2   = 1'b0;
        #12;
        check("reset busy/done", {busy8, done8}, 32'd0);
        check("reset sum", sum8, 32'd0);
        check("reset carry", carry8, 32'd0);
        check("reset w2", {busy2, done2, carry2, sum2}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        launch8(8'h5A, 8'h3C, 1'b0);
        finish8("add_5a_3c", 8'h96, 1'b0, 1'b0);
        idle8("add_5a_3c", 8'h96, 1'b0);

        launch8(8'hFF, 8'h01, 1'b0);
        finish8("add_ff_01", 8'h00, 1'b1, 1'b0);
        launch8(8'h00, 8'h00, 1'b0);
        finish8("b2b_00_00", 8'h00, 1'b0, 1'b0);
        idle8("b2b_00_00", 8'h00, 1'b0);

        launch8(8'h10, 8'h20, 1'b0);
        finish8("ignore_busy", 8'h30, 1'b0, 1'b1);
        idle8("ignore_busy", 8'h30, 1'b0);

        // Abort in the 4th ADD cycle: three bits of 0x33+0x44 are already in sum.
        launch8(8'h33, 8'h44, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("abort pre-reset busy", busy8, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("abort busy/done", {busy8, done8}, 32'd0);
        check("abort sum", sum8, 32'd0);
        check("abort carry", carry8, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        launch8(8'h33, 8'h44, 1'b0);
        finish8("after_reset", 8'h77, 1'b0, 1'b0);
        idle8("after_reset", 8'h77, 1'b0);

        launch8(8'h80, 8'h80, 1'b0);
        finish8("add_80_80", 8'h00, 1'b1, 1'b0);
        launch8(8'hA5, 8'h5A, 1'b0);
        finish8("add_a5_5a", 8'hFF, 1'b0, 1'b0);
        idle8("add_a5_5a", 8'hFF, 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
        launch8(8'h10, 8'h01, 1'b1);
        finish8("sub_10_01", 8'h0F, 1'b1, 1'b0);
        launch8(8'h01, 8'h02, 1'b1);
        finish8("sub_01_02", 8'hFF, 1'b0, 1'b0);
        launch8(8'h55, 8'h55, 1'b1);
        finish8("sub_55_55", 8'h00, 1'b1, 1'b0);
        launch8(8'h01, 8'h01, 1'b0);
        finish8("add_after_sub", 8'h02, 1'b0, 1'b0);
        idle8("add_after_sub", 8'h02, 1'b0);
`endif

        // WIDTH=2 sweep, each operation started in the previous DONE cycle.
        for (int m = 0; m < NMODE; m++) begin
            for (int x = 0; x < 4; x++) begin
                for (int y = 0; y < 4; y++) begin
                    a2     = 2'(x);
                    b2     = 2'(y);
                    sub2   = (m == 1);
                    start2 = 1'b1;
                    @(posedge clk); #1;
                    start2 = 1'b0;
                    exp_v  = (m == 1) ? (x + (3 - y) + 1) : (x + y);
                    repeat (2) begin
                        check($sformatf("w2 m%0d %0d,%0d busy", m, x, y), {busy2, done2}, 32'd2);
                        @(posedge clk); #1;
                    end
                    check($sformatf("w2 m%0d %0d,%0d done", m, x, y), {busy2, done2}, 32'd1);
                    check($sformatf("w2 m%0d %0d,%0d sum", m, x, y), sum2, 32'(exp_v[1:0]));
                    check($sformatf("w2 m%0d %0d,%0d carry", m, x, y), carry2, 32'(exp_v[2]));
                end
            end
        end
        @(posedge clk); #1;
        check("w2 final idle", {busy2, done2}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
